// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths, fetch state encoding and constants
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;
  typedef enum logic {FETCH = 1'b0, HALT = 1'b1} fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular fetch buffer with flush taking priority over push and pop
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) if (push && !flush && !rst) mem[wr_ptr] <= push_data;
  assign head_data = mem[rd_ptr];
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: fetch PC, redirect/fault FSM and fetch buffer feeding decode
module inst_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int MEM_WORDS = 1024,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fault,
  output logic [31:0] fault_pc
);
  localparam logic [XLEN-1:0] MEM_BYTES = XLEN'(MEM_WORDS * 4);
  fetch_state_t state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN+INSTR_W-1:0] head;
  logic [$clog2(FIFO_DEPTH):0] count;
  logic empty, full, pop, push, flush, legal, room;
  logic unused_count;
  assign unused_count = ^count;
  assign legal = redirect_valid && redirect_pc[1:0] == 2'b00 && redirect_pc < MEM_BYTES;
  assign pop = !empty && out_ready;
  assign room = !full || pop;
  // an illegal redirect while already halted only updates fault_pc; the buffer keeps draining
  assign flush = legal || (redirect_valid && state == FETCH);
  assign push = state == FETCH && !redirect_valid && fetch_pc < MEM_BYTES && room;
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC;
      fault_pc <= '0;
    end else if (legal) begin
      state    <= FETCH;
      fetch_pc <= redirect_pc;
    end else if (redirect_valid) begin
      state    <= HALT;
      fault_pc <= redirect_pc;
    end else if (state == FETCH && fetch_pc >= MEM_BYTES) begin
      state    <= HALT;
      fault_pc <= fetch_pc;
    end else if (push) begin
      fetch_pc <= fetch_pc + 32'd4;
    end
  end
  fetch_fifo #(.WIDTH(XLEN + INSTR_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data ({fetch_pc, imem_rdata}),
    .pop       (pop),
    .head_data (head),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );
  assign imem_addr = fetch_pc;
  assign fault = state == HALT;
  assign out_valid = !empty;
  assign out_pc = empty ? '0 : head[XLEN+INSTR_W-1:INSTR_W];
  assign out_instr = empty ? '0 : head[INSTR_W-1:0];
endmodule
